demux_dispatch_ctrl: RTL and testbench
======================================

// Module: demux_dispatch_ctrl
// PURPOSE
//   Sequencer for the N-bit 1x8 demux on the CPU write-back/route path.
//   Buffers incoming (data, dest) words in a 2-deep FIFO and drives the demux
//   input bus and selects (S2..S0). Raises a one-hot per-destination valid and
//   holds each word until the selected sink accepts it.
//   Sits between the producing stage and the eight destination sinks.
// PARAMETERS
//   N        32  data width; matches the demux datapath width
//   TIMEOUT  15  wait cycles before a word is dropped (used only with the macro)
// PORTS
//   clk         in   1    single clock; all state updates on posedge
//   rst_n       in   1    synchronous reset, active-low
//   in_valid    in   1    producer has a word
//   in_ready    out  1    controller can accept a word
//   in_data     in   N    word to route
//   in_dest     in   3    destination index 0..7
//   dmx_data    out  N    to demux I
//   dmx_sel     out  3    to demux {S2,S1,S0}
//   out_valid   out  8    one-hot valid, bit d = destination Yd
//   out_ready   in   8    per-destination ready
//   busy        out  1    word in output stage or FIFO non-empty
//   err_timeout out  1    one-cycle pulse when a word is dropped
//   err_dest    out  3    destination of the last dropped word
// BEHAVIOUR
//   - Reset (rst_n=0 at posedge): FIFO count=0, state IDLE, dmx_data=0,
//     dmx_sel=0, out_valid=0, err_timeout=0, err_dest=0.
//     in_ready is gated to 0 while rst_n=0.
//   - in_ready = rst_n && (fifo_count < 2); combinational from registered count.
//     A pop in the same cycle does not raise in_ready (no ready pass-through).
//   - Push on in_valid && in_ready. Order is strictly FIFO.
//   - FSM IDLE:
//     - FIFO non-empty: pop head. Next edge loads dmx_data, dmx_sel=dest and
//       out_valid=1<<dest, then DRIVE.
//     - Minimum latency: accept edge t, out_valid high after edge t+1.
//   - FSM DRIVE:
//     - Outputs are held stable.
//     - Transfer completes at a posedge with out_valid[d] && out_ready[d].
//     - out_ready bits other than d are ignored.
//     - On completion with FIFO non-empty at that edge: load the next word
//       back-to-back (no bubble) and stay in DRIVE.
//     - On completion with FIFO empty: out_valid=0, go to IDLE. dmx_data and
//       dmx_sel keep their last value.
//   - Push and pop in the same cycle: count unchanged; the pushed word goes to
//     the tail.
//   - Capacity: 1 word in the output stage + 2 in the FIFO = 3 words.
//   - busy = (state==DRIVE) || (fifo_count!=0).
//   - Reset mid-transfer: all held and buffered words are discarded; out_valid
//     is 0 after that edge.
// CONFIGURATION
//   DEMUX_DISPATCH_TIMEOUT_EN defined:
//   - A wait counter clears on each load and counts cycles spent in DRIVE
//     without completion.
//   - When out_valid has been high for TIMEOUT cycles without ready:
//     - the word is dropped;
//     - err_timeout pulses high for 1 cycle and err_dest=dest;
//     - the FSM proceeds as on completion (next word or IDLE).
//   - Counter width is $clog2(TIMEOUT+1).
//   DEMUX_DISPATCH_TIMEOUT_EN undefined:
//   - DRIVE waits indefinitely.
//   - err_timeout and err_dest are tied to 0; ports are still present.
// TESTING
//   1. rst_n=0 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0,
//      dmx_sel=0. After release: in_ready=1, busy=0.
//   2. Push 32'd12321, dest=3, out_ready=8'hFF -> next cycle dmx_data=12321,
//      dmx_sel=3'b011, out_valid=8'h08. Following cycle out_valid=0, busy=0.
//   3. out_ready=0; push dest 0,5,7,2 back-to-back -> first 3 accepted,
//      in_ready=0 on the 4th. Set out_ready=8'hFF -> out_valid 01,20,80 on
//      consecutive cycles, then 4th accepted.
//   4. Dest 3, out_ready=8'b1111_0111 for 5 cycles -> out_valid=8'h08 held,
//      data stable. Set bit3 -> completes in 1 cycle.
//   5. Sweep dest 0..7 with 12321, out_ready=8'hFF -> out_valid
//      01,02,04,...,80 and dmx_sel 0..7 in order, one per cycle, no bubbles.
//   6. (TIMEOUT_EN, TIMEOUT=4) dest 6, out_ready=0 -> after 4 cycles of
//      out_valid=8'h40: err_timeout 1-cycle pulse, err_dest=6, out_valid=0.

Source files
------------

// File: rtl/demux_dispatch_ctrl.sv
// Dispatch sequencer for a 1x8 demux: 2-deep input FIFO, one held output word, one-hot valid.
// Optional drop-on-timeout is enabled by defining DEMUX_DISPATCH_TIMEOUT_EN.
module demux_dispatch_ctrl #(
    parameter int N       = 32,
    parameter int TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic [2:0]   in_dest,
    output logic [N-1:0] dmx_data,
    output logic [2:0]   dmx_sel,
    output logic [7:0]   out_valid,
    input  logic [7:0]   out_ready,
    output logic         busy,
    output logic         err_timeout,
    output logic [2:0]   err_dest
);

    typedef enum logic {
        IDLE,
        DRIVE
    } state_t;

    typedef struct packed {
        logic [N-1:0] data;
        logic [2:0]   dest;
    } word_t;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    state_t     state;
    word_t      fifo_mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] fifo_count;
    word_t      head;

    logic push;
    logic pop;
    logic done;
    logic expire;
    logic release_word;

    // Ready looks only at the registered count, so a same-cycle pop never opens a slot early.
    assign in_ready     = rst_n && (fifo_count < 2'd2);
    assign push         = in_valid && in_ready;
    assign head         = fifo_mem[rd_ptr];
    assign done         = (state == DRIVE) && ((out_valid & out_ready) != 8'd0);
    assign release_word = done || expire;
    assign pop          = (fifo_count != 2'd0) && ((state == IDLE) || release_word);
    assign busy         = (state == DRIVE) || (fifo_count != 2'd0);

    // NOTE: sequential state uses <= so every register samples pre-edge values,
    // independent of the order the statements are written in.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fifo_count <= 2'd0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // NOTE: storage is left unreset; the count and pointers decide what is valid,
    // and push is already gated off while rst_n is low.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= '{data: in_data, dest: in_dest};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            dmx_data  <= '0;
            dmx_sel   <= '0;
            out_valid <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        dmx_data  <= head.data;
                        dmx_sel   <= head.dest;
                        out_valid <= 8'b1 << head.dest;
                        state     <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (release_word) begin
                        if (pop) begin
                            dmx_data  <= head.data;
                            dmx_sel   <= head.dest;
                            out_valid <= 8'b1 << head.dest;
                        end else begin
                            // data and select keep their last value on the way back to IDLE
                            out_valid <= '0;
                            state     <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

`ifdef DEMUX_DISPATCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wait_cnt;

    // Expiry on the edge that ends the TIMEOUT-th cycle of out_valid high; completion wins a tie.
    assign expire = (state == DRIVE) && !done && (wait_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt    <= '0;
            err_timeout <= 1'b0;
            err_dest    <= '0;
        end else begin
            err_timeout <= expire;
            if (expire) err_dest <= dmx_sel;
            if (pop || release_word || (state == IDLE)) wait_cnt <= '0;
            else                                          wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    assign expire      = 1'b0;
    assign err_timeout = 1'b0;
    assign err_dest    = 3'd0;
`endif

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Self-checking bench for demux_dispatch_ctrl: directed sequences, a sweep table and a random
// stream, all words tracked by a queue scoreboard; timeout checks when DEMUX_DISPATCH_TIMEOUT_EN is set.
module tb_demux_dispatch_ctrl;

    localparam int N = 32;
`ifdef DEMUX_DISPATCH_TIMEOUT_EN
    localparam int TB_TIMEOUT = 4;
    localparam int HOLD       = 1;
`else
    localparam int TB_TIMEOUT = 15;
    localparam int HOLD       = 5;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic [2:0]   in_dest;
    logic [N-1:0] dmx_data;
    logic [2:0]   dmx_sel;
    logic [7:0]   out_valid;
    logic [7:0]   out_ready;
    logic         busy;
    logic         err_timeout;
    logic [2:0]   err_dest;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [N-1:0] data;
        logic [2:0]   dest;
    } word_t;

    typedef struct {
        logic [N-1:0] data;
        logic [2:0]   dest;
        logic [7:0]   exp_valid;
    } vec_t;

    word_t exp_q[$];
    vec_t  sweep[8];

    demux_dispatch_ctrl #(.N(N), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_dest     (in_dest),
        .dmx_data    (dmx_data),
        .dmx_sel     (dmx_sel),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .err_timeout (err_timeout),
        .err_dest    (err_dest)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Drive on the falling edge, then settle 2 time units before anyone samples.
    task automatic step(input logic v, input logic [N-1:0] d, input logic [2:0] dst,
                        input logic [7:0] rdy);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_dest   = dst;
        out_ready = rdy;
        #2;
    endtask

    // Scoreboard monitor: same sample point as the stimulus, predicts the coming posedge.
    initial begin
        word_t w;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n !== 1'b1) begin
                exp_q.delete();
            end else begin
                if (err_timeout === 1'b1) begin
                    if (exp_q.size() == 0) check("drop_underflow", 64'(exp_q.size()), 64'd1);
                    else begin
                        w = exp_q.pop_front();
                        check("drop_dest", 64'(err_dest), 64'(w.dest));
                    end
                end
                if (out_valid !== 8'd0) check("valid_onehot", 64'(out_valid), 64'(8'b1 << dmx_sel));
                if ((out_valid & out_ready) != 8'd0) begin
                    if (exp_q.size() == 0) check("sb_underflow", 64'(exp_q.size()), 64'd1);
                    else begin
                        w = exp_q.pop_front();
                        check("sb_data", 64'(dmx_data), 64'(w.data));
                        check("sb_sel", 64'(dmx_sel), 64'(w.dest));
                    end
                end
                if (in_valid && in_ready) exp_q.push_back('{data: in_data, dest: in_dest});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            sweep[i].data      = 32'd12321;
            sweep[i].dest      = 3'(i);
            sweep[i].exp_valid = 8'b1 << i;
        end

        // Reset held with a word offered: nothing accepted, outputs cleared.
        rst_n = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_dest = 3'd5; out_ready = 8'hFF;
        step(1'b1, 32'hDEAD_BEEF, 3'd5, 8'hFF);
        step(1'b1, 32'hDEAD_BEEF, 3'd5, 8'hFF);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sel", 64'(dmx_sel), 64'd0);
        check("rst_data", 64'(dmx_data), 64'd0);
        check("rst_err", 64'({err_timeout, err_dest}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        #2;
        check("rel_in_ready", 64'(in_ready), 64'd1);
        check("rel_busy", 64'(busy), 64'd0);

        // Single word, sink always ready: one cycle of latency, then a one-cycle transfer.
        step(1'b1, 32'd12321, 3'd3, 8'hFF);
        check("t2_in_ready", 64'(in_ready), 64'd1);
        step(1'b0, '0, 3'd0, 8'hFF);
        check("t2_latency_valid", 64'(out_valid), 64'd0);
        check("t2_latency_busy", 64'(busy), 64'd1);
        step(1'b0, '0, 3'd0, 8'hFF);
        check("t2_data", 64'(dmx_data), 64'd12321);
        check("t2_sel", 64'(dmx_sel), 64'd3);
        check("t2_valid", 64'(out_valid), 64'h08);
        step(1'b0, '0, 3'd0, 8'hFF);
        check("t2_done_valid", 64'(out_valid), 64'd0);
        check("t2_done_busy", 64'(busy), 64'd0);
        check("t2_sel_kept", 64'(dmx_sel), 64'd3);

        // Capacity: three words accepted while stalled, fourth held off until a slot frees.
        step(1'b1, 32'h1000_0000, 3'd0, 8'h00);
        check("t3_rdy0", 64'(in_ready), 64'd1);
        step(1'b1, 32'h1000_0005, 3'd5, 8'h00);
        check("t3_rdy1", 64'(in_ready), 64'd1);
        step(1'b1, 32'h1000_0007, 3'd7, 8'h00);
        check("t3_rdy2", 64'(in_ready), 64'd1);
        step(1'b1, 32'h1000_0002, 3'd2, 8'h00);
        check("t3_full", 64'(in_ready), 64'd0);
        check("t3_hold_valid", 64'(out_valid), 64'h01);
        step(1'b1, 32'h1000_0002, 3'd2, 8'hFF);
        check("t3_pop_no_passthru", 64'(in_ready), 64'd0);
        check("t3_v0", 64'(out_valid), 64'h01);
        step(1'b1, 32'h1000_0002, 3'd2, 8'hFF);
        check("t3_v1", 64'(out_valid), 64'h20);
        check("t3_rdy_after_pop", 64'(in_ready), 64'd1);
        step(1'b0, '0, 3'd0, 8'hFF);
        check("t3_v2", 64'(out_valid), 64'h80);
        step(1'b0, '0, 3'd0, 8'hFF);
        check("t3_v3", 64'(out_valid), 64'h04);
        check("t3_d3", 64'(dmx_data), 64'h1000_0002);
        step(1'b0, '0, 3'd0, 8'hFF);
        check("t3_idle", 64'(out_valid), 64'd0);

        // Only the selected ready bit matters.
        step(1'b1, 32'hCAFE_0003, 3'd3, 8'hF7);
        step(1'b0, '0, 3'd0, 8'hF7);
        step(1'b0, '0, 3'd0, 8'hF7);
        check("t4_valid", 64'(out_valid), 64'h08);
        for (int k = 0; k < HOLD; k++) begin
            step(1'b0, '0, 3'd0, 8'hF7);
            check("t4_hold_valid", 64'(out_valid), 64'h08);
            check("t4_hold_data", 64'(dmx_data), 64'hCAFE_0003);
        end
        step(1'b0, '0, 3'd0, 8'h08);
        check("t4_last_valid", 64'(out_valid), 64'h08);
        step(1'b0, '0, 3'd0, 8'h00);
        check("t4_done", 64'(out_valid), 64'd0);
        check("t4_no_err", 64'(err_timeout), 64'd0);

        // Sweep table: one word per cycle, no bubbles.
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                step(1'b1, sweep[i].data, sweep[i].dest, 8'hFF);
                check("sweep_ready", 64'(in_ready), 64'd1);
            end else begin
                step(1'b0, '0, 3'd0, 8'hFF);
            end
            if (i >= 2) begin
                check("sweep_valid", 64'(out_valid), 64'(sweep[i-2].exp_valid));
                check("sweep_sel", 64'(dmx_sel), 64'(sweep[i-2].dest));
            end
        end
        step(1'b0, '0, 3'd0, 8'hFF);
        check("sweep_end", 64'(out_valid), 64'd0);

        // Reset mid-transfer discards the held and buffered words.
        step(1'b1, 32'hAAAA_0001, 3'd1, 8'h00);
        step(1'b1, 32'hAAAA_0004, 3'd4, 8'h00);
        step(1'b1, 32'hAAAA_0006, 3'd6, 8'h00);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        #2;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);

`ifdef DEMUX_DISPATCH_TIMEOUT_EN
        // Stalled word dropped after TIMEOUT cycles of valid.
        step(1'b1, 32'hBBBB_0006, 3'd6, 8'h00);
        step(1'b0, '0, 3'd0, 8'h00);
        step(1'b0, '0, 3'd0, 8'h00);
        check("t6_valid0", 64'(out_valid), 64'h40);
        for (int k = 1; k < TB_TIMEOUT; k++) begin
            step(1'b0, '0, 3'd0, 8'h00);
            check("t6_valid_held", 64'(out_valid), 64'h40);
            check("t6_no_pulse", 64'(err_timeout), 64'd0);
        end
        step(1'b0, '0, 3'd0, 8'h00);
        check("t6_pulse", 64'(err_timeout), 64'd1);
        check("t6_err_dest", 64'(err_dest), 64'd6);
        check("t6_valid_off", 64'(out_valid), 64'd0);
        step(1'b0, '0, 3'd0, 8'h00);
        check("t6_pulse_end", 64'(err_timeout), 64'd0);
        check("t6_dest_kept", 64'(err_dest), 64'd6);
`endif

        // Random stream with random sink readiness.
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), N'($urandom), 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom));
        end
        begin
            int budget;
            budget = 0;
            do begin
                step(1'b0, '0, 3'd0, 8'hFF);
                budget++;
            end while (busy && budget < 20);
            check("drain_busy", 64'(busy), 64'd0);
        end
        step(1'b0, '0, 3'd0, 8'hFF);
        check("sb_empty", 64'(exp_q.size()), 64'd0);
`ifndef DEMUX_DISPATCH_TIMEOUT_EN
        check("no_err_dest", 64'(err_dest), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
